crc_frame_feeder: RTL

CRC_FRAME_FEEDER -- requirements
Module: crc_frame_feeder

---
 rtl/crc_frame_feeder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/crc_frame_feeder.sv
// =============================================================================
// crc_frame_feeder : byte FIFO that releases fixed-length framed bursts to a
//                    downstream CRC stage and waits for its completion.
// Revision: 1.0
// =============================================================================
`default_nettype none

module crc_frame_feeder #(
  parameter int FRAME_LEN = 32,
  parameter int DEPTH     = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_first,
  output logic                   out_last,
  input  logic                   crc_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   frame_abort
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;
  localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [c_lw-1:0] c_frame_len = c_lw'(FRAME_LEN);
  localparam logic [c_lw-1:0] c_last_idx  = c_lw'(FRAME_LEN - 1);
  localparam logic [c_lw-1:0] c_depth     = c_lw'(DEPTH);
  localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TIMEOUT - 1);
  localparam logic            c_single    = (FRAME_LEN == 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STREAM    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_lw-1:0] r_level;
  logic [c_lw-1:0] r_idx;
  logic [c_tw-1:0] r_wait;
  state_t          r_state;

  state_t          w_state_nx;
  logic            w_push;
  logic            w_pop;
  logic            w_valid_nx;
  logic            w_first_nx;
  logic            w_last_nx;
  logic [c_lw-1:0] w_idx_nx;
  logic [c_tw-1:0] w_wait_nx;
  logic            w_tmo_nx;
  logic            w_abort_nx;

  assign in_ready = (r_level < c_depth);
  assign w_push   = in_valid && in_ready && !flush;
  assign level    = r_level;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_valid_nx = 1'b0;
    w_first_nx = 1'b0;
    w_last_nx  = 1'b0;
    w_idx_nx   = r_idx;
    w_wait_nx  = r_wait;
    w_tmo_nx   = 1'b0;
    w_abort_nx = 1'b0;
    if (flush) begin
      w_state_nx = S_IDLE;
      w_abort_nx = (r_state == S_STREAM);
      w_idx_nx   = '0;
      w_wait_nx  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_level >= c_frame_len) begin
            w_pop      = 1'b1;
            w_valid_nx = 1'b1;
            w_first_nx = 1'b1;
            w_last_nx  = c_single;
            w_idx_nx   = c_lw'(1);
            w_state_nx = S_STREAM;
          end
        end
        S_STREAM: begin
          // r_idx counts bytes already presented; the frame was fully buffered
          // before it started, so a pop here can never underflow.
          if (r_idx < c_frame_len) begin
            w_pop      = 1'b1;
            w_valid_nx = 1'b1;
            w_last_nx  = (r_idx == c_last_idx);
            w_idx_nx   = r_idx + c_lw'(1);
          end else begin
            w_wait_nx  = '0;
            w_state_nx = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (crc_done) begin
            w_state_nx = S_IDLE;
          end else if (r_wait == c_tmo_last) begin
            w_tmo_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_wait_nx  = r_wait + c_tw'(1);
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      timeout_err <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_wait      <= w_wait_nx;
      out_valid   <= w_valid_nx;
      out_first   <= w_first_nx;
      out_last    <= w_last_nx;
      timeout_err <= w_tmo_nx;
      frame_abort <= w_abort_nx;
      if (w_pop) begin
        out_data <= r_mem[r_rd_ptr];
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + c_lw'(1);
          2'b01:   r_level <= r_level - c_lw'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
